// File: rtl/tiny_cpu_pkg.sv
// Shared definitions for the tiny CPU data-memory slice.
//   WordW / BeW   : data word width and byte-enable width
//   dmem_state_e  : request FSM states (idle, wait states, response)
//   addr_err()    : misaligned or out-of-range word address check
package tiny_cpu_pkg;

  localparam int unsigned WordW = 32;
  localparam int unsigned BeW   = WordW / 8;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp
  } dmem_state_e;

  // The full 30-bit word index is compared, so any address past the array
  // (including ones whose low index bits would wrap) is rejected, never aliased.
  function automatic logic addr_err(logic [WordW-1:0] addr, int unsigned depth);
    return (addr[1:0] != 2'b00) || ({2'b00, addr[WordW-1:2]} >= depth);
  endfunction

endpackage

// File: rtl/tiny_dmem_array.sv
// DEPTH x 32-bit single-port RAM with per-byte write enables and a
// registered read port.
//   clk_i   : clock
//   we_i    : write strobe, bytes selected by be_i
//   re_i    : read strobe, rdata_o updates on the same edge
//   addr_i  : word index
//   wdata_i : write data
//   rdata_o : read data register
// Contents have no reset.
module tiny_dmem_array
  import tiny_cpu_pkg::*;
#(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned Aw    = 6
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic             re_i,
  input  logic [Aw-1:0]    addr_i,
  input  logic [BeW-1:0]   be_i,
  input  logic [WordW-1:0] wdata_i,
  output logic [WordW-1:0] rdata_o
);

  logic [WordW-1:0] mem_q [DEPTH];
  logic [WordW-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < int'(BeW); b++) begin
        if (be_i[b]) begin
          mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
    if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/tiny_dmem.sv
// Tiny data memory with a valid/ready request channel and a valid/ready
// response channel, one outstanding request, WAIT_CYC wait states.
//   CLK, RST          : clock, synchronous active-high reset
//   req_valid/ready   : request handshake (ready only when idle)
//   req_we            : 1 = store, 0 = load
//   req_addr          : byte address (word aligned)
//   req_wdata, req_be : store data and byte enables
//   rsp_valid/ready   : response handshake, outputs held until accepted
//   rsp_rdata         : load data, 0 for stores and errors
//   rsp_err           : misaligned or out-of-range request
// Stores commit at the acceptance edge; loads read on the edge entering RESP.
module tiny_dmem
  import tiny_cpu_pkg::*;
#(
  parameter int unsigned DEPTH    = 64,
  parameter int unsigned WAIT_CYC = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [WordW-1:0] req_addr,
  input  logic [WordW-1:0] req_wdata,
  input  logic [BeW-1:0]   req_be,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WordW-1:0] rsp_rdata,
  output logic             rsp_err
);

  localparam int unsigned Aw = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  dmem_state_e      state_q;
  logic [1:0]       cnt_q;
  logic             we_q;
  logic [WordW-1:0] addr_q;
  logic             rsp_valid_q;
  logic             rsp_err_q;
  logic             rsp_rd_q;

  logic             accept;
  logic             cur_we;
  logic [WordW-1:0] cur_addr;
  logic             cur_err;
  logic             enter_resp;
  logic             arr_we;
  logic             arr_re;
  logic [WordW-1:0] arr_rdata;

  // In IDLE the live request drives the array, otherwise the captured one;
  // this lets WAIT_CYC = 0 read at the acceptance edge itself.
  always_comb begin
    accept     = (state_q == StIdle) && req_valid && !RST;
    cur_we     = accept ? req_we : we_q;
    cur_addr   = accept ? req_addr : addr_q;
    cur_err    = addr_err(cur_addr, DEPTH);
    enter_resp = (accept && (WAIT_CYC == 0)) || ((state_q == StWait) && (cnt_q == 2'd1));
    arr_we     = accept && req_we && !cur_err;
    arr_re     = enter_resp && !cur_we && !cur_err && !RST;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= StIdle;
      cnt_q       <= 2'd0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rd_q    <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (accept) begin
            we_q   <= req_we;
            addr_q <= req_addr;
            if (WAIT_CYC == 0) begin
              state_q     <= StResp;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= cur_err;
              rsp_rd_q    <= arr_re;
            end else begin
              state_q <= StWait;
              cnt_q   <= 2'(WAIT_CYC);
            end
          end
        end
        StWait: begin
          if (cnt_q == 2'd1) begin
            state_q     <= StResp;
            cnt_q       <= 2'd0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= cur_err;
            rsp_rd_q    <= arr_re;
          end else begin
            cnt_q <= cnt_q - 2'd1;
          end
        end
        StResp: begin
          if (rsp_ready) begin
            state_q     <= StIdle;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rd_q    <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  tiny_dmem_array #(
    .DEPTH (DEPTH),
    .Aw    (Aw)
  ) u_array (
    .clk_i   (CLK),
    .we_i    (arr_we),
    .re_i    (arr_re),
    .addr_i  (cur_addr[Aw+1:2]),
    .be_i    (req_be),
    .wdata_i (req_wdata),
    .rdata_o (arr_rdata)
  );

  assign req_ready = (state_q == StIdle);
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  // The read register only holds meaningful data for a good load.
  assign rsp_rdata = rsp_rd_q ? arr_rdata : '0;

endmodule

// File: tb/tb_tiny_dmem.sv
// Bench for tiny_dmem: three instances with WAIT_CYC = 0, 1, 3 share one
// vector table; hand sequences cover stalls, resets and throughput.
module tb_tiny_dmem;

  localparam int unsigned DEPTH = 64;
  localparam int NDUT = 3;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          t_acc;
  } exp_t;

  logic        clk;
  logic        rst       [NDUT];
  logic        req_valid [NDUT];
  logic        req_ready [NDUT];
  logic        req_we    [NDUT];
  logic [31:0] req_addr  [NDUT];
  logic [31:0] req_wdata [NDUT];
  logic [3:0]  req_be    [NDUT];
  logic        rsp_valid [NDUT];
  logic        rsp_ready [NDUT];
  logic [31:0] rsp_rdata [NDUT];
  logic        rsp_err   [NDUT];

  int   checks;
  int   errors;
  exp_t sb[$];
  vec_t vecs[$];

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    tiny_dmem #(
      .DEPTH    (DEPTH),
      .WAIT_CYC ((g == 0) ? 0 : (g == 1) ? 1 : 3)
    ) u_dut (
      .CLK       (clk),
      .RST       (rst[g]),
      .req_valid (req_valid[g]),
      .req_ready (req_ready[g]),
      .req_we    (req_we[g]),
      .req_addr  (req_addr[g]),
      .req_wdata (req_wdata[g]),
      .req_be    (req_be[g]),
      .rsp_valid (rsp_valid[g]),
      .rsp_ready (rsp_ready[g]),
      .rsp_rdata (rsp_rdata[g]),
      .rsp_err   (rsp_err[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int wait_of(int d);
    return (d == 0) ? 0 : (d == 1) ? 1 : 3;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic pop_exp(output exp_t e, output bit ok);
    ok = (sb.size() != 0);
    if (ok) e = sb.pop_front();
    else begin
      checks++;
      errors++;
      $display("FAIL scoreboard: response with no expected entry");
    end
  endtask

  // Starts and ends on a negedge. Drives one request, checks the response
  // against the scoreboard, its latency, and the return to idle.
  task automatic run_xact(int d, logic we, logic [31:0] addr, logic [31:0] wdata,
                          logic [3:0] be, logic [31:0] erd, logic eerr, string name);
    int   lat;
    exp_t e;
    bit   ok;
    check({name, " req_ready"}, 32'(req_ready[d]), 32'd1);
    req_valid[d] = 1'b1;
    req_we[d]    = we;
    req_addr[d]  = addr;
    req_wdata[d] = wdata;
    req_be[d]    = be;
    sb.push_back('{rdata: erd, err: eerr, t_acc: 0});
    @(negedge clk);
    req_valid[d] = 1'b0;
    lat = 1;
    while (!rsp_valid[d] && lat < 16) begin
      @(negedge clk);
      lat++;
    end
    pop_exp(e, ok);
    if (!rsp_valid[d]) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: no rsp_valid after %0d cycles", name, lat);
      return;
    end
    if (ok) begin
      check({name, " rdata"}, rsp_rdata[d], e.rdata);
      check({name, " err"}, 32'(rsp_err[d]), 32'(e.err));
    end
    check({name, " latency"}, 32'(lat), 32'(wait_of(d) + 1));
    rsp_ready[d] = 1'b1;
    @(negedge clk);
    rsp_ready[d] = 1'b0;
    check({name, " rsp_valid drop"}, 32'(rsp_valid[d]), 32'd0);
  endtask

  // Continuous load requests with rsp_ready high: one transaction every
  // WAIT_CYC+2 cycles.
  task automatic run_thru(int d, int n);
    int   acc;
    int   rsp;
    int   cyc;
    exp_t e;
    bit   ok;
    acc = 0;
    rsp = 0;
    cyc = n * (wait_of(d) + 2);
    req_valid[d] = 1'b1;
    req_we[d]    = 1'b0;
    req_addr[d]  = 32'h0;
    req_be[d]    = 4'h0;
    rsp_ready[d] = 1'b1;
    for (int t = 0; t < cyc; t++) begin
      if (rsp_valid[d]) begin
        rsp++;
        pop_exp(e, ok);
        if (ok) begin
          check("thru rdata", rsp_rdata[d], e.rdata);
          check("thru latency", 32'(t - e.t_acc), 32'(wait_of(d) + 1));
        end
      end
      if (req_ready[d]) begin
        acc++;
        sb.push_back('{rdata: 32'h2A, err: 1'b0, t_acc: t});
      end
      @(negedge clk);
    end
    req_valid[d] = 1'b0;
    rsp_ready[d] = 1'b0;
    check("thru accepts", 32'(acc), 32'(n));
    check("thru responses", 32'(rsp), 32'(n));
    check("thru sb empty", 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  task automatic wait_rsp(int d, string name);
    int n;
    n = 0;
    while (!rsp_valid[d] && n < 16) begin
      @(negedge clk);
      n++;
    end
    check({name, " rsp_valid"}, 32'(rsp_valid[d]), 32'd1);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int d = 0; d < NDUT; d++) begin
      rst[d]       = 1'b1;
      req_valid[d] = 1'b0;
      req_we[d]    = 1'b0;
      req_addr[d]  = '0;
      req_wdata[d] = '0;
      req_be[d]    = '0;
      rsp_ready[d] = 1'b0;
    end

    vecs.push_back('{1'b1, 32'h0000_0000, 32'h0000_002A, 4'hF, 32'h0, 1'b0});
    vecs.push_back('{1'b0, 32'h0000_0000, 32'h0,         4'h0, 32'h0000_002A, 1'b0});
    vecs.push_back('{1'b1, 32'h0000_0004, 32'hAABB_CCDD, 4'hF, 32'h0, 1'b0});
    vecs.push_back('{1'b1, 32'h0000_0004, 32'h1122_3344, 4'h5, 32'h0, 1'b0});
    vecs.push_back('{1'b0, 32'h0000_0004, 32'h0,         4'h0, 32'hAA22_CC44, 1'b0});
    vecs.push_back('{1'b0, 32'h0000_0002, 32'h0,         4'h0, 32'h0, 1'b1});
    vecs.push_back('{1'b0, 32'(4 * DEPTH), 32'h0,        4'h0, 32'h0, 1'b1});
    vecs.push_back('{1'b0, 32'hFFFF_FFFC, 32'h0,         4'h0, 32'h0, 1'b1});
    vecs.push_back('{1'b1, 32'h0000_0002, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b1});
    vecs.push_back('{1'b1, 32'(4 * DEPTH), 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b1});
    vecs.push_back('{1'b1, 32'h4000_0000, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b1});
    vecs.push_back('{1'b1, 32'h0000_0000, 32'hFFFF_FFFF, 4'h0, 32'h0, 1'b0});
    vecs.push_back('{1'b0, 32'h0000_0000, 32'h0,         4'h0, 32'h0000_002A, 1'b0});
    vecs.push_back('{1'b0, 32'h0000_0004, 32'h0,         4'h0, 32'hAA22_CC44, 1'b0});
    vecs.push_back('{1'b1, 32'(4 * DEPTH - 4), 32'h0000_0055, 4'hF, 32'h0, 1'b0});
    vecs.push_back('{1'b0, 32'(4 * DEPTH - 4), 32'h0,    4'h0, 32'h0000_0055, 1'b0});
    vecs.push_back('{1'b0, 32'h0000_0000, 32'h0,         4'h0, 32'h0000_002A, 1'b0});

    repeat (2) @(negedge clk);
    for (int d = 0; d < NDUT; d++) rst[d] = 1'b0;
    for (int d = 0; d < NDUT; d++) begin
      check("reset req_ready", 32'(req_ready[d]), 32'd1);
      check("reset rsp_valid", 32'(rsp_valid[d]), 32'd0);
      check("reset rsp_rdata", rsp_rdata[d], 32'd0);
      check("reset rsp_err", 32'(rsp_err[d]), 32'd0);
    end

    for (int d = 0; d < NDUT; d++) begin
      for (int i = 0; i < vecs.size(); i++) begin
        run_xact(d, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be,
                 vecs[i].rdata, vecs[i].err, $sformatf("dut%0d vec%0d", d, i));
      end
    end

    // Response stall with a competing request that must be ignored.
    req_valid[1] = 1'b1;
    req_we[1]    = 1'b0;
    req_addr[1]  = 32'h4;
    @(negedge clk);
    req_valid[1] = 1'b0;
    wait_rsp(1, "stall");
    for (int i = 0; i < 5; i++) begin
      req_valid[1] = 1'b1;
      req_we[1]    = 1'b1;
      req_addr[1]  = 32'h0;
      req_wdata[1] = 32'h0000_0BAD;
      req_be[1]    = 4'hF;
      check("stall rsp_valid", 32'(rsp_valid[1]), 32'd1);
      check("stall rdata", rsp_rdata[1], 32'hAA22_CC44);
      check("stall req_ready", 32'(req_ready[1]), 32'd0);
      @(negedge clk);
    end
    req_valid[1] = 1'b0;
    rsp_ready[1] = 1'b1;
    @(negedge clk);
    rsp_ready[1] = 1'b0;
    check("stall release", 32'(rsp_valid[1]), 32'd0);
    run_xact(1, 1'b0, 32'h0, 32'h0, 4'h0, 32'h2A, 1'b0, "after stall");

    // Reset while in WAIT (WAIT_CYC = 3).
    req_valid[2] = 1'b1;
    req_we[2]    = 1'b0;
    req_addr[2]  = 32'h0;
    @(negedge clk);
    req_valid[2] = 1'b0;
    check("rstwait in wait", 32'(rsp_valid[2]), 32'd0);
    rst[2] = 1'b1;
    @(negedge clk);
    rst[2] = 1'b0;
    check("rstwait rsp_valid", 32'(rsp_valid[2]), 32'd0);
    check("rstwait req_ready", 32'(req_ready[2]), 32'd1);
    begin
      int seen;
      seen = 0;
      rsp_ready[2] = 1'b1;
      repeat (6) begin
        @(negedge clk);
        if (rsp_valid[2]) seen++;
      end
      rsp_ready[2] = 1'b0;
      check("rstwait no response", 32'(seen), 32'd0);
    end
    run_xact(2, 1'b0, 32'h0, 32'h0, 4'h0, 32'h2A, 1'b0, "rstwait persist");

    // Reset while in RESP.
    req_valid[1] = 1'b1;
    req_we[1]    = 1'b0;
    req_addr[1]  = 32'h4;
    @(negedge clk);
    req_valid[1] = 1'b0;
    wait_rsp(1, "rstresp");
    rst[1] = 1'b1;
    @(negedge clk);
    rst[1] = 1'b0;
    check("rstresp rsp_valid", 32'(rsp_valid[1]), 32'd0);
    check("rstresp rdata", rsp_rdata[1], 32'd0);
    check("rstresp req_ready", 32'(req_ready[1]), 32'd1);
    run_xact(1, 1'b0, 32'h4, 32'h0, 4'h0, 32'hAA22_CC44, 1'b0, "rstresp persist");

    for (int d = 0; d < NDUT; d++) run_thru(d, 5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tiny_dmem.md
TINY_DMEM -- requirements
Module: tiny_dmem

Interface
REQ-001 SHALL have parameter DEPTH, default 64, number of 32-bit words in the memory.
REQ-002 SHALL have parameter WAIT_CYC, default 1, wait states between request acceptance and response (legal 0..3).
REQ-003 SHALL have port CLK, input, 1, single system clock, all logic on rising edge.
REQ-004 SHALL have port RST, input, 1, synchronous active-high reset.
REQ-005 SHALL have port req_valid, input, 1, CPU load/store request present.
REQ-006 SHALL have port req_ready, output, 1, block can accept a request this cycle.
REQ-007 SHALL have port req_we, input, 1, 1 = store (SW), 0 = load (LW).
REQ-008 SHALL have port req_addr, input, 32, byte address.
REQ-009 SHALL have port req_wdata, input, 32, store data.
REQ-010 SHALL have port req_be, input, 4, byte enables for stores, bit i = byte i (little-endian).
REQ-011 SHALL have port rsp_valid, output, 1, response present.
REQ-012 SHALL have port rsp_ready, input, 1, CPU accepts response.
REQ-013 SHALL have port rsp_rdata, output, 32, load data; 0 for stores and errors.
REQ-014 SHALL have port rsp_err, output, 1, request was misaligned or out of range.

Function
REQ-015 SHALL accept a request on a cycle where req_valid && req_ready, capturing we/addr/wdata/be into internal registers.
REQ-016 SHALL implement FSM IDLE -> WAIT -> RESP -> IDLE; IDLE goes directly to RESP when WAIT_CYC = 0.
REQ-017 SHALL assert req_ready only in IDLE; one outstanding request maximum.
REQ-018 SHALL count WAIT_CYC cycles in WAIT with a down-counter loaded at acceptance, moving to RESP when it reaches 1.
REQ-019 SHALL assert rsp_valid in RESP and hold rsp_valid, rsp_rdata, rsp_err stable until rsp_valid && rsp_ready, then return to IDLE.
REQ-020 SHALL give response latency of WAIT_CYC+1 cycles from acceptance edge to rsp_valid high.
REQ-021 SHALL flag error when req_addr[1:0] != 0 or word index req_addr[31:2] >= DEPTH; errored requests SHALL NOT modify memory, rsp_rdata = 0.
REQ-022 SHALL perform a store at the acceptance edge, writing only bytes with req_be set; req_be = 0 is a legal no-op store with rsp_err = 0.
REQ-023 SHALL return for a load the full word at the captured address, read on the edge entering RESP.
REQ-024 SHALL return store-then-load to the same address with the new data (no stale read).
REQ-025 SHALL ignore req_valid while not in IDLE; request inputs SHALL NOT be latched then.
REQ-026 SHALL treat a word index wrap as out of range, never aliasing.

Reset
REQ-027 SHALL on RST force state IDLE, req_ready = 1 after the reset edge, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, wait counter = 0.
REQ-028 SHALL abandon any in-flight request on RST, including one in RESP, without emitting a response.
REQ-029 SHALL NOT clear memory contents on RST; a store already committed before RST SHALL persist.

Structure
REQ-030 SHALL place state enum (IDLE, WAIT, RESP), the 32-bit word width and the byte-enable width in shared package tiny_cpu_pkg.
REQ-031 SHALL contain one sub-module tiny_dmem_array: DEPTH x 32 synchronous byte-writable RAM, one port.

Verification
REQ-032 SHALL cover: SW 0x0000002A to addr 0 (be=4'hF), then LW addr 0 -> rsp_rdata = 0x2A, rsp_err = 0, latency WAIT_CYC+1.
REQ-033 SHALL cover: SW 0xAABBCCDD to addr 4, then SW 0x11223344 with be=4'b0101, then LW addr 4 -> 0xAA22CC44.
REQ-034 SHALL cover: LW addr 0x2 and LW addr 4*DEPTH -> rsp_err = 1, rsp_rdata = 0; SW to those addresses leaves memory unchanged.
REQ-035 SHALL cover: rsp_ready held low 5 cycles in RESP -> rsp_valid/rsp_rdata stable, req_ready = 0, second req_valid ignored.
REQ-036 SHALL cover: RST asserted in WAIT during an LW -> next cycle rsp_valid = 0, req_ready = 1; data stored before RST still reads back.
REQ-037 SHALL cover: WAIT_CYC = 0 and WAIT_CYC = 3 builds -> response at 1 and 4 cycles after acceptance, back-to-back requests sustained.
